// File: rtl/ysyx_23060240_lsu_if.sv
// Execute-stage / memory-access-stage / writeback signal bundle around the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline.
interface ysyx_23060240_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [2:0]  memory_rd_ctrl;
  logic [7:0]  memory_wr_ctrl;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_misalign;
  logic        out_illegal;
  logic [31:0] out_badaddr;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    input  mem_rd_data, out_ready,
    output in_ready, mem_rd_en, mem_wr_en, memory_rd_ctrl, memory_wr_ctrl,
    output mem_rd_addr, mem_wr_addr, mem_wr_data,
    output out_valid, out_rdata, out_rd, out_wen, out_misalign, out_illegal, out_badaddr
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    output mem_rd_data, out_ready,
    input  in_ready, mem_rd_en, mem_wr_en, memory_rd_ctrl, memory_wr_ctrl,
    input  mem_rd_addr, mem_wr_addr, mem_wr_data,
    input  out_valid, out_rdata, out_rd, out_wen, out_misalign, out_illegal, out_badaddr
  );
endinterface

// File: rtl/ysyx_23060240_lsu.sv
// Single-op load/store unit: decodes and checks one access, holds the memory port for
// LATENCY cycles, then presents the result under a valid/ready handshake.
module ysyx_23060240_lsu #(
  parameter int unsigned LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  ysyx_23060240_lsu_if.slave bus
);

  localparam int unsigned    CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      rd_ctrl_q, rd_ctrl_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     out_rdata_q, out_rdata_d;
  logic [31:0]     out_badaddr_q, out_badaddr_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic            out_misalign_q, out_misalign_d;
  logic            out_illegal_q, out_illegal_d;

  logic            dec_illegal, dec_misalign;
  logic [2:0]      dec_rd_ctrl;
  logic [3:0]      dec_mask;
  logic [31:0]     dec_wdata;

  // Decode of the presented op; misalignment is only flagged for legal encodings.
  always_comb begin
    dec_illegal  = 1'b0;
    dec_misalign = 1'b0;
    dec_rd_ctrl  = 3'b000;
    dec_mask     = 4'b0000;
    dec_wdata    = bus.in_wdata;
    if (bus.in_is_store) begin
      case (bus.in_funct3)
        3'b000: begin
          dec_mask  = 4'b0001 << bus.in_addr[1:0];
          dec_wdata = {4{bus.in_wdata[7:0]}};
        end
        3'b001: begin
          dec_mask     = 4'b0011 << bus.in_addr[1:0];
          dec_wdata    = {2{bus.in_wdata[15:0]}};
          dec_misalign = bus.in_addr[0];
        end
        3'b010: begin
          dec_mask     = 4'b1111;
          dec_misalign = |bus.in_addr[1:0];
        end
        default: dec_illegal = 1'b1;
      endcase
    end else if (bus.in_is_load) begin
      case (bus.in_funct3)
        3'b000: dec_rd_ctrl = 3'b001;
        3'b001: begin
          dec_rd_ctrl  = 3'b011;
          dec_misalign = bus.in_addr[0];
        end
        3'b010: begin
          dec_rd_ctrl  = 3'b101;
          dec_misalign = |bus.in_addr[1:0];
        end
        3'b100: dec_rd_ctrl = 3'b010;
        3'b101: begin
          dec_rd_ctrl  = 3'b100;
          dec_misalign = bus.in_addr[0];
        end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_illegal = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_store_d     = is_store_q;
    rd_ctrl_d      = rd_ctrl_q;
    mask_d         = mask_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    out_rdata_d    = out_rdata_q;
    out_badaddr_d  = out_badaddr_q;
    out_rd_d       = out_rd_q;
    out_wen_d      = out_wen_q;
    out_misalign_d = out_misalign_q;
    out_illegal_d  = out_illegal_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          is_store_d = bus.in_is_store;
          rd_ctrl_d  = dec_rd_ctrl;
          mask_d     = dec_mask;
          addr_d     = bus.in_addr;
          wdata_d    = dec_wdata;
          rd_d       = bus.in_rd;
          if (dec_illegal || dec_misalign) begin
            state_d        = StDone;
            out_illegal_d  = dec_illegal;
            out_misalign_d = dec_misalign;
            out_badaddr_d  = bus.in_addr;
          end else begin
            state_d = StAccess;
            cnt_d   = CntMax;
          end
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!is_store_q) begin
            out_rdata_d = bus.mem_rd_data;
            out_rd_d    = rd_q;
            out_wen_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d        = StIdle;
          out_rdata_d    = '0;
          out_badaddr_d  = '0;
          out_rd_d       = '0;
          out_wen_d      = 1'b0;
          out_misalign_d = 1'b0;
          out_illegal_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      is_store_q     <= 1'b0;
      rd_ctrl_q      <= '0;
      mask_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      out_rdata_q    <= '0;
      out_badaddr_q  <= '0;
      out_rd_q       <= '0;
      out_wen_q      <= 1'b0;
      out_misalign_q <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_store_q     <= is_store_d;
      rd_ctrl_q      <= rd_ctrl_d;
      mask_q         <= mask_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      out_rdata_q    <= out_rdata_d;
      out_badaddr_q  <= out_badaddr_d;
      out_rd_q       <= out_rd_d;
      out_wen_q      <= out_wen_d;
      out_misalign_q <= out_misalign_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  // Memory-side outputs decode from the state register so a reset drops them at once.
  logic ld_access, st_access;
  assign ld_access = (state_q == StAccess) && !is_store_q;
  assign st_access = (state_q == StAccess) && is_store_q;

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.mem_rd_en      = ld_access;
  assign bus.mem_wr_en      = st_access && (cnt_q == CntMax);
  assign bus.memory_rd_ctrl = ld_access ? rd_ctrl_q : 3'b000;
  assign bus.memory_wr_ctrl = st_access ? {4'b0000, mask_q} : 8'h00;
  assign bus.mem_rd_addr    = ld_access ? addr_q : 32'h0;
  assign bus.mem_wr_addr    = st_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wr_data    = st_access ? wdata_q : 32'h0;
  assign bus.out_valid      = (state_q == StDone);
  assign bus.out_rdata      = out_rdata_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_wen        = out_wen_q;
  assign bus.out_misalign   = out_misalign_q;
  assign bus.out_illegal    = out_illegal_q;
  assign bus.out_badaddr    = out_badaddr_q;

endmodule

// File: doc/ysyx_23060240_lsu.md
# ysyx_23060240_lsu

Load/store unit sitting between the execute stage and the memory-access stage. Accepts one decoded load/store per handshake, checks alignment and funct3 legality, and drives the memory-access stage's control/address/data inputs for a parameterised number of cycles. It then captures the sized, extended read data and holds a result for writeback under a valid/ready handshake. One operation in flight at a time; no buffering beyond the single result register.

## Interface
- LATENCY, 1: cycles the memory port is held per access (>=1); read data captured on the last one.

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  unit can accept; high only in IDLE
- in_is_load / in_is_store  in  1 each  operation kind; store wins if both set
- in_funct3  in  3  RV32I funct3 of the load/store
- in_addr  in  32  effective byte address
- in_wdata  in  32  store source data
- in_rd  in  5  destination register of a load
- mem_rd_en / mem_wr_en  out  1 each  read/write strobes to memory-access stage
- memory_rd_ctrl  out  3  001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 000 none
- memory_wr_ctrl  out  8  byte-lane write mask; bits 7:4 always 0
- mem_rd_addr  out  32  byte address of the load (unmodified)
- mem_wr_addr  out  32  word-aligned store address, {in_addr[31:2],2'b00}
- mem_wr_data  out  32  lane-replicated store data
- mem_rd_data  in  32  sized and extended read data from memory-access stage
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_rdata  out  32  load result; 0 for stores/faults
- out_rd  out  5  load destination; 0 for stores/faults
- out_wen  out  1  register write required (legal, aligned load)
- out_misalign  out  1  alignment fault; no memory access performed
- out_illegal  out  1  illegal funct3 or neither kind set; no memory access performed
- out_badaddr  out  32  in_addr of faulting op, else 0

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: in_ready=1. On in_valid: latch operation and decode.
  - Legal and aligned: go to ACCESS, count = LATENCY-1.
  - Otherwise: go straight to DONE with the fault flag set and out_badaddr=in_addr.
- Load decode: 000->001, 001->011, 010->101, 100->010, 101->100. funct3 011/110/111 is illegal.
- Store decode: 000 sb, 001 sh, 010 sw; anything else is illegal.
  - sb: data={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0].
  - sh: data={2{wdata[15:0]}}, mask=4'b0011<<addr[1:0].
  - sw: data=wdata, mask=4'b1111.
- Misaligned: half ops with addr[0]=1; word ops with addr[1:0]!=0. Illegal takes priority over misaligned.
- ACCESS, load: mem_rd_en=1 every ACCESS cycle; memory_rd_ctrl held. On the last cycle (count==0), out_rdata<=mem_rd_data, then go to DONE.
- ACCESS, store: mem_wr_en=1 in the first ACCESS cycle only, so exactly one write per store. Address, data and mask are held for all LATENCY cycles.
- DONE: out_valid=1, all outputs stable until out_ready. On out_valid&&out_ready go to IDLE and clear out_* flags.
- Enables are 0 outside ACCESS. memory_rd_ctrl is 000 outside load ACCESS; memory_wr_ctrl is 0 outside store ACCESS.

## Timing
- Reset (async, immediate): state IDLE, in_ready=1; every other output 0, including all memory-side registers.
- Handshake accepted at edge E0: ACCESS occupies cycles E0+1..E0+LATENCY; out_valid rises at E0+LATENCY+1.
- Fault path: out_valid rises at E0+1 and no enable is ever asserted.
- out_ready high on the first DONE cycle: in_ready is high the next cycle. Minimum period is LATENCY+2 cycles per legal op and 2 per faulting op.
- in_* are ignored while in_ready=0. The upstream stage holds them until accepted.
- Reset mid-ACCESS: enables drop at once and the op is discarded. A store whose write cycle has not yet occurred is never written.
- Reset during DONE: the result is lost and out_valid drops.

## Test plan
- lw addr 0x8000_0010, LATENCY=1, mem_rd_data=0xDEADBEEF -> rd_ctrl=101 one cycle; out_valid at E0+2; out_rdata=0xDEADBEEF, out_wen=1.
- sb addr 0x8000_0003, wdata 0x1234_56A5 -> single mem_wr_en pulse; wr_addr 0x8000_0000, mask 8'h08, data 0xA5A5A5A5.
- sh addr 0x8000_0002, LATENCY=3 -> mem_wr_en high only in ACCESS cycle 1, mask 8'h0C; out_valid at E0+4; out_wen=0.
- lw addr 0x8000_0006 -> no enables; out_valid at E0+1, out_misalign=1, out_badaddr=0x8000_0006. Load funct3=011 -> out_illegal=1.
- out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; ready pulse -> in_ready=1 the next cycle.
- rst_n low in the middle of a LATENCY=3 load -> enables 0 immediately; after release in_ready=1, out_valid=0, all outputs 0.
